// File: rtl/add_share_arb_if.sv
// Request/response bundle for the shared-adder arbiter: NREQ packed requesters in,
// one in-order result stream out.
interface add_share_arb_if #(
    parameter int NREQ = 4,
    parameter int W    = 8
) ();
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   req_cin;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [W-1:0]      rsp_sum;
    logic              rsp_cout;
    logic [15:0]       done_cnt;

    modport slave (
        input  req_valid, req_a, req_b, req_cin, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, done_cnt
    );

    modport master (
        output req_valid, req_a, req_b, req_cin, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, done_cnt
    );
endinterface

// File: rtl/add_share_arb.sv
// Round-robin arbiter sharing one Kogge-Stone adder between NREQ requesters,
// with a two-stage (operand / result) elastic pipeline and a consumed-result counter.
module add_share_arb_pfx #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);
    always_comb begin
        logic [W-1:0] g, p, gn, pn, hp;
        hp = a ^ b;
        g  = a & b;
        p  = hp;
        // Fold carry-in into bit 0 so g[i] becomes the carry out of bits [i:0].
        g[0] = g[0] | (p[0] & cin);
        for (int unsigned d = 1; d < W; d = d * 2) begin
            gn = g;
            pn = p;
            for (int unsigned i = d; i < W; i++) begin
                gn[i] = g[i] | (p[i] & g[i-d]);
                pn[i] = p[i] & p[i-d];
            end
            g = gn;
            p = pn;
        end
        sum  = hp ^ {g[W-2:0], cin};
        cout = g[W-1];
    end
endmodule

module add_share_arb #(
    parameter int NREQ = 4,
    parameter int W    = 8
) (
    input logic              clk,
    input logic              rst_n,
    add_share_arb_if.slave   bus
);
    localparam int IDW = $clog2(NREQ);

    logic           s1_v, s2_v;
    logic [W-1:0]   s1_a, s1_b;
    logic           s1_cin;
    logic [IDW-1:0] s1_id, s2_id;
    logic [W-1:0]   s2_sum, add_sum;
    logic           s2_cout, add_cout;
    logic [IDW-1:0] rr_ptr, win;
    logic [15:0]    cnt;
    logic           any, s2_load, s1_adv, s1_load, xfer;

    assign s2_load = !s2_v || bus.rsp_ready;
    assign s1_adv  = s1_v && s2_load;
    assign s1_load = !s1_v || s2_load;
    assign xfer    = rst_n && any && s1_load;

    always_comb begin
        int unsigned idx;
        any = 1'b0;
        win = '0;
        idx = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (k + 32'(rr_ptr)) % NREQ;
            if (!any && bus.req_valid[idx]) begin
                any = 1'b1;
                win = IDW'(idx);
            end
        end
    end

    always_comb begin
        bus.req_ready = '0;
        if (xfer) bus.req_ready[win] = 1'b1;
    end

    add_share_arb_pfx #(.W(W)) u_add (
        .a    (s1_a),
        .b    (s1_b),
        .cin  (s1_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Operand payload needs no reset: it is only consumed while s1_v is set.
    always_ff @(posedge clk) begin
        if (xfer) begin
            s1_a   <= bus.req_a[win*W +: W];
            s1_b   <= bus.req_b[win*W +: W];
            s1_cin <= bus.req_cin[win];
            s1_id  <= win;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_v    <= 1'b0;
            s2_v    <= 1'b0;
            rr_ptr  <= '0;
            cnt     <= '0;
            s2_sum  <= '0;
            s2_cout <= 1'b0;
            s2_id   <= '0;
        end else begin
            if (xfer) begin
                s1_v   <= 1'b1;
                rr_ptr <= (win == IDW'(NREQ-1)) ? '0 : win + 1'b1;
            end else if (s1_adv) begin
                s1_v <= 1'b0;
            end
            if (s2_load) s2_v <= s1_v;
            if (s1_adv) begin
                s2_sum  <= add_sum;
                s2_cout <= add_cout;
                s2_id   <= s1_id;
            end
            if (s2_v && bus.rsp_ready) cnt <= cnt + 16'd1;
        end
    end

    assign bus.rsp_valid = s2_v && rst_n;
    assign bus.rsp_id    = s2_id;
    assign bus.rsp_sum   = s2_sum;
    assign bus.rsp_cout  = s2_cout;
    assign bus.done_cnt  = cnt;
endmodule

// File: tb/tb_add_share_arb.sv
// Bench for add_share_arb: directed vector table, hand-written pipeline sequences,
// randomized traffic against a queue-based model, and a done_cnt wrap run.
module tb_add_share_arb;
    localparam int NREQ = 4;
    localparam int W    = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    add_share_arb_if #(.NREQ(NREQ), .W(W)) bus ();

    add_share_arb #(.NREQ(NREQ), .W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int       id;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] sum;
        logic       cout;
    } vec_t;

    typedef struct {
        int id;
        int val;
        int vis;
    } ent_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b, input logic cin);
        bus.req_a[i*W +: W] = a;
        bus.req_b[i*W +: W] = b;
        bus.req_cin[i]      = cin;
    endtask

    task automatic idle();
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_cin   = '0;
        bus.rsp_ready = 1'b0;
    endtask

    // Returns at a negedge with rst_n just released and inputs idle.
    task automatic do_reset();
        @(negedge clk);
        idle();
        rst_n = 1'b0;
        bus.req_valid = '1;
        #1;
        chk("rst_ready", 32'(bus.req_ready), 0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.req_valid = '0;
        #1;
        chk("rst_done_cnt", 32'(bus.done_cnt), 0);
        chk("rst_rsp_sum", 32'(bus.rsp_sum), 0);
        chk("rst_rsp_cout", 32'(bus.rsp_cout), 0);
        chk("rst_rsp_id", 32'(bus.rsp_id), 0);
        chk("rst_rsp_valid_after", 32'(bus.rsp_valid), 0);
    endtask

    task automatic chk_rsp(input string name, input int id, input logic [7:0] sum, input logic cout);
        chk({name, "_valid"}, 32'(bus.rsp_valid), 1);
        chk({name, "_id"}, 32'(bus.rsp_id), 32'(id));
        chk({name, "_sum"}, 32'(bus.rsp_sum), 32'(sum));
        chk({name, "_cout"}, 32'(bus.rsp_cout), 32'(cout));
    endtask

    task automatic run_vectors();
        do_reset();
        foreach (vecs[n]) begin
            bus.rsp_ready = 1'b1;
            set_req(vecs[n].id, vecs[n].a, vecs[n].b, vecs[n].cin);
            bus.req_valid = NREQ'(1 << vecs[n].id);
            #1;
            chk("vec_ready", 32'(bus.req_ready), 32'(1 << vecs[n].id));
            @(negedge clk);
            bus.req_valid = '0;
            #1;
            chk("vec_lat1", 32'(bus.rsp_valid), 0);
            @(negedge clk);
            #1;
            chk_rsp("vec", vecs[n].id, vecs[n].sum, vecs[n].cout);
            @(negedge clk);
            #1;
            chk("vec_drained", 32'(bus.rsp_valid), 0);
        end
    endtask

    task automatic run_round_robin();
        do_reset();
        bus.rsp_ready = 1'b1;
        bus.req_valid = '1;
        for (int i = 0; i < NREQ; i++) set_req(i, 8'(i + 1), 8'h10, 1'b0);
        for (int c = 0; c < 7; c++) begin
            #1;
            chk("rr_grant", 32'(bus.req_ready), 32'(1 << (c % NREQ)));
            if (c >= 2) chk_rsp("rr_rsp", (c - 2) % NREQ, 8'((c - 2) % NREQ + 1 + 16), 1'b0);
            else        chk("rr_rsp_early", 32'(bus.rsp_valid), 0);
            @(negedge clk);
        end
        idle();
        bus.rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic run_backpressure();
        do_reset();
        bus.req_valid = 4'b1010;
        set_req(1, 8'h21, 8'h01, 1'b0);
        set_req(3, 8'hF0, 8'h20, 1'b0);
        #1;
        chk("bp_grant0", 32'(bus.req_ready), 32'b0010);
        chk("bp_rv0", 32'(bus.rsp_valid), 0);
        @(negedge clk);
        #1;
        chk("bp_grant1", 32'(bus.req_ready), 32'b1000);
        chk("bp_rv1", 32'(bus.rsp_valid), 0);
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("bp_stall_ready", 32'(bus.req_ready), 0);
            chk_rsp("bp_stall", 1, 8'h22, 1'b0);
            @(negedge clk);
        end
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        #1;
        chk_rsp("bp_drain0", 1, 8'h22, 1'b0);
        @(negedge clk);
        #1;
        chk_rsp("bp_drain1", 3, 8'h10, 1'b1);
        @(negedge clk);
        #1;
        chk("bp_empty", 32'(bus.rsp_valid), 0);
        chk("bp_done_cnt", 32'(bus.done_cnt), 2);
    endtask

    task automatic run_reset_mid();
        do_reset();
        bus.req_valid = 4'b0110;
        #1;
        chk("rm_grant0", 32'(bus.req_ready), 32'b0010);
        @(negedge clk);
        #1;
        chk("rm_grant1", 32'(bus.req_ready), 32'b0100);
        @(negedge clk);
        #1;
        chk("rm_full_ready", 32'(bus.req_ready), 0);
        chk("rm_full_rv", 32'(bus.rsp_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("rm_inrst_ready", 32'(bus.req_ready), 0);
        chk("rm_inrst_rv", 32'(bus.rsp_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.req_valid = '1;
        bus.rsp_ready = 1'b1;
        set_req(0, 8'h3C, 8'h03, 1'b0);
        #1;
        chk("rm_rv_after", 32'(bus.rsp_valid), 0);
        chk("rm_done_cnt", 32'(bus.done_cnt), 0);
        chk("rm_grant_ptr0", 32'(bus.req_ready), 32'b0001);
        @(negedge clk);
        bus.req_valid = '0;
        #1;
        chk("rm_no_stale", 32'(bus.rsp_valid), 0);
        @(negedge clk);
        #1;
        chk_rsp("rm_fresh", 0, 8'h3F, 1'b0);
        @(negedge clk);
        #1;
        chk("rm_empty", 32'(bus.rsp_valid), 0);
        chk("rm_done_cnt1", 32'(bus.done_cnt), 1);
    endtask

    task automatic run_random(input int cycles);
        ent_t q[$];
        int ptr = 0;
        int edges = 0;
        int consumed = 0;
        logic [7:0] ra[NREQ];
        logic [7:0] rb[NREQ];
        logic       rc[NREQ];
        logic [NREQ-1:0] v;
        logic rdy;
        do_reset();
        for (int it = 0; it < cycles; it++) begin
            int w = 0;
            bit any = 0;
            bit acc, rv;
            v   = NREQ'($urandom_range(0, (1 << NREQ) - 1));
            rdy = ($urandom_range(0, 9) < 7);
            for (int i = 0; i < NREQ; i++) begin
                ra[i] = 8'($urandom);
                rb[i] = 8'($urandom);
                rc[i] = 1'($urandom);
                set_req(i, ra[i], rb[i], rc[i]);
            end
            bus.req_valid = v;
            bus.rsp_ready = rdy;
            #1;
            for (int k = 0; k < NREQ; k++) begin
                int idx = (ptr + k) % NREQ;
                if (!any && v[idx]) begin
                    any = 1;
                    w = idx;
                end
            end
            acc = any && (q.size() < 2 || rdy);
            rv  = (q.size() > 0) && (edges >= q[0].vis);
            chk("rnd_ready", 32'(bus.req_ready), acc ? 32'(1 << w) : 32'd0);
            chk("rnd_rsp_valid", 32'(bus.rsp_valid), 32'(rv));
            if (rv) begin
                chk("rnd_rsp_id", 32'(bus.rsp_id), 32'(q[0].id));
                chk("rnd_rsp_result", {23'd0, bus.rsp_cout, bus.rsp_sum}, 32'(q[0].val));
            end
            chk("rnd_done_cnt", 32'(bus.done_cnt), 32'(consumed % 65536));
            @(posedge clk);
            edges++;
            if (rv && rdy) begin
                void'(q.pop_front());
                consumed++;
                if (q.size() > 0 && q[0].vis < edges) q[0].vis = edges;
            end
            if (acc) begin
                q.push_back('{w, int'(ra[w]) + int'(rb[w]) + int'(rc[w]), edges + 1});
                ptr = (w + 1) % NREQ;
            end
            @(negedge clk);
        end
        idle();
    endtask

    task automatic run_wrap();
        int  cons = 0;
        bit  reached = 0;
        do_reset();
        bus.req_valid = 4'b0001;
        bus.rsp_ready = 1'b1;
        for (int c = 0; c < 70000 && !reached; c++) begin
            #1;
            if (bus.rsp_valid) begin
                if (cons == 65536) chk("wrap_at_65536", 32'(bus.done_cnt), 0);
                cons++;
                if (cons == 65537) reached = 1;
            end
            @(negedge clk);
        end
        bus.req_valid = '0;
        bus.rsp_ready = 1'b0;
        #1;
        chk("wrap_reached", 32'(reached), 1);
        chk("wrap_done_cnt", 32'(bus.done_cnt), 1);
    endtask

    initial begin
        vecs[0] = '{2, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[1] = '{1, 8'h7F, 8'h80, 1'b1, 8'h00, 1'b1};
        vecs[2] = '{3, 8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
        vecs[3] = '{0, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
        vecs[4] = '{3, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[5] = '{2, 8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0};

        rst_n = 1'b0;
        idle();
        run_vectors();
        run_round_robin();
        run_backpressure();
        run_reset_mid();
        run_random(2000);
        run_wrap();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
